// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared types and constants for the multiply/divide unit.
//   - InstrType opcode encodings used by the MDU (7-bit)
//   - MDUStateType controller states (IDLE/MUL/DIV/FIX)
//   - accumulate mode type and opcode decode helpers
// Configuration macro: MDU_ACC_EN adds MADD/MADDU/MSUB/MSUBU to the MDU op set.
package mdu_ctrl_pkg;

    typedef logic [6:0] instr_t;

    localparam instr_t OP_NOP   = 7'h00;
    localparam instr_t OP_ADD   = 7'h01;
    localparam instr_t OP_MULT  = 7'h18;
    localparam instr_t OP_MULTU = 7'h19;
    localparam instr_t OP_DIV   = 7'h1A;
    localparam instr_t OP_DIVU  = 7'h1B;
    localparam instr_t OP_MTHI  = 7'h1C;
    localparam instr_t OP_MTLO  = 7'h1D;
    localparam instr_t OP_MFHI  = 7'h1E;
    localparam instr_t OP_MFLO  = 7'h1F;
    localparam instr_t OP_MADD  = 7'h20;
    localparam instr_t OP_MADDU = 7'h21;
    localparam instr_t OP_MSUB  = 7'h22;
    localparam instr_t OP_MSUBU = 7'h23;

    localparam int unsigned DIV_ITERS = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} MDUStateType;

    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

    function automatic logic is_mdu_op(input instr_t op);
        logic w_hit;
        w_hit = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV)  || (op == OP_DIVU) ||
                (op == OP_MTHI) || (op == OP_MTLO)  || (op == OP_MFHI) || (op == OP_MFLO);
`ifdef MDU_ACC_EN
        w_hit = w_hit || (op == OP_MADD) || (op == OP_MADDU) ||
                (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return w_hit;
    endfunction

    function automatic logic is_mul_op(input instr_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input instr_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input instr_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic acc_e acc_mode(input instr_t op);
        acc_e w_mode;
        w_mode = ACC_NONE;
`ifdef MDU_ACC_EN
        if ((op == OP_MADD) || (op == OP_MADDU)) w_mode = ACC_ADD;
        if ((op == OP_MSUB) || (op == OP_MSUBU)) w_mode = ACC_SUB;
`endif
        return w_mode;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EXE-stage <-> MDU signal bundle.
//   master (pipeline): drives EXE_Op/EXE_Start/EXE_Flush/EXE_BusA/EXE_BusB,
//                      reads MDU_Stall/MDU_Busy/HI/LO
//   slave  (mdu_ctrl): the mirror image
interface mdu_ctrl_if;
    logic [6:0]  EXE_Op;
    logic        EXE_Start;
    logic        EXE_Flush;
    logic [31:0] EXE_BusA;
    logic [31:0] EXE_BusB;
    logic        MDU_Stall;
    logic        MDU_Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output EXE_Op, EXE_Start, EXE_Flush, EXE_BusA, EXE_BusB,
        input  MDU_Stall, MDU_Busy, HI, LO
    );

    modport slave (
        input  EXE_Op, EXE_Start, EXE_Flush, EXE_BusA, EXE_BusB,
        output MDU_Stall, MDU_Busy, HI, LO
    );
endinterface

// File: rtl/mdu_div.sv
// mdu_div: unsigned iterative radix-2 restoring divider, one quotient bit per cycle.
//   clk, rst     : clock, asynchronous active-low reset
//   i_start      : load operands (pulse); iteration begins next cycle
//   i_dividend   : 32-bit unsigned dividend
//   i_divisor    : 32-bit unsigned divisor
//   o_done       : high once all DIV_ITERS iterations have completed, until next start
//   o_quot/o_rem : quotient/remainder (valid while o_done)
// Divide by zero naturally yields quotient all-ones and remainder = dividend.
module mdu_div
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_run;
    logic        r_done;
    logic [32:0] w_trial;

    // Partial remainder shifted left by one with the next dividend bit, minus divisor.
    assign w_trial = {r_rem, r_quot[31]} - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dvs  <= i_divisor;
            r_cnt  <= 6'(DIV_ITERS);
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            if (!w_trial[32]) begin
                r_rem  <= w_trial[31:0];
                r_quot <= {r_quot[30:0], 1'b1};
            end else begin
                r_rem  <= {r_rem[30:0], r_quot[31]};
                r_quot <= {r_quot[30:0], 1'b0};
            end
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EXE-stage multiply/divide controller owning the HI/LO registers.
//   clk, rst  : clock, asynchronous active-low reset
//   bus.slave : EXE_Op/EXE_Start/EXE_Flush/EXE_BusA/EXE_BusB in;
//               MDU_Stall (comb), MDU_Busy (registered state), HI, LO out
// Parameter MUL_CYCLES (1..8): multiply latency.
// Configuration macro: MDU_ACC_EN enables MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    mdu_ctrl_if.slave bus
);

    localparam logic [4:0] MUL_INIT = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_INIT = 5'(DIV_ITERS - 1);

    MDUStateType r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_opa, w_opa_nxt;
    logic [31:0] r_opb, w_opb_nxt;
    logic        r_signed, w_signed_nxt;
    acc_e        r_acc, w_acc_nxt;
    logic        r_neg_q, w_neg_q_nxt;
    logic        r_neg_r, w_neg_r_nxt;

    logic        w_busy;
    logic        w_valid;
    logic        w_go;
    logic        w_op_signed;
    logic        w_div_start;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_div_done;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;

    assign w_busy      = (r_state != IDLE);
    assign w_valid     = bus.EXE_Start & ~bus.EXE_Flush & is_mdu_op(bus.EXE_Op);
    assign w_go        = w_valid & ~w_busy;
    assign w_op_signed = is_signed_op(bus.EXE_Op);
    assign w_div_start = w_go & is_div_op(bus.EXE_Op);

    // Divider core only ever sees magnitudes; signs are restored in FIX.
    assign w_abs_a = (w_op_signed && bus.EXE_BusA[31]) ? -bus.EXE_BusA : bus.EXE_BusA;
    assign w_abs_b = (w_op_signed && bus.EXE_BusB[31]) ? -bus.EXE_BusB : bus.EXE_BusB;

    mdu_div u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Low 64 bits of the extended operands' product are the exact 32x32 result.
    assign w_prod = {{32{r_signed & r_opa[31]}}, r_opa} * {{32{r_signed & r_opb[31]}}, r_opb};

    always_comb begin
        w_mul_res = w_prod;
        unique case (r_acc)
            ACC_ADD: w_mul_res = {r_hi, r_lo} + w_prod;
            ACC_SUB: w_mul_res = {r_hi, r_lo} - w_prod;
            default: w_mul_res = w_prod;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_opa_nxt    = r_opa;
        w_opb_nxt    = r_opb;
        w_signed_nxt = r_signed;
        w_acc_nxt    = r_acc;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        unique case (r_state)
            IDLE: begin
                if (w_go) begin
                    if (is_mul_op(bus.EXE_Op)) begin
                        w_state_nxt  = MUL;
                        w_cnt_nxt    = MUL_INIT;
                        w_opa_nxt    = bus.EXE_BusA;
                        w_opb_nxt    = bus.EXE_BusB;
                        w_signed_nxt = w_op_signed;
                        w_acc_nxt    = acc_mode(bus.EXE_Op);
                    end else if (is_div_op(bus.EXE_Op)) begin
                        w_state_nxt = DIV;
                        w_cnt_nxt   = DIV_INIT;
                        w_neg_q_nxt = w_op_signed & (bus.EXE_BusA[31] ^ bus.EXE_BusB[31]);
                        w_neg_r_nxt = w_op_signed & bus.EXE_BusA[31];
                    end else if (bus.EXE_Op == OP_MTHI) begin
                        w_hi_nxt = bus.EXE_BusA;
                    end else if (bus.EXE_Op == OP_MTLO) begin
                        w_lo_nxt = bus.EXE_BusA;
                    end
                end
            end
            MUL: begin
                if (r_cnt == 5'd0) begin
                    {w_hi_nxt, w_lo_nxt} = w_mul_res;
                    w_state_nxt          = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            DIV: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = FIX;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            FIX: begin
                if (w_div_done) begin
                    w_hi_nxt    = r_neg_r ? -w_rem : w_rem;
                    w_lo_nxt    = r_neg_q ? -w_quot : w_quot;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_signed <= 1'b0;
            r_acc    <= ACC_NONE;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_opa    <= w_opa_nxt;
            r_opb    <= w_opb_nxt;
            r_signed <= w_signed_nxt;
            r_acc    <= w_acc_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
        end
    end

    assign bus.MDU_Stall = w_valid & w_busy;
    assign bus.MDU_Busy  = w_busy;
    assign bus.HI        = r_hi;
    assign bus.LO        = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (MUL_CYCLES = 2).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// With MDU_ACC_EN defined the accumulate ops are exercised, otherwise their absence.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_cyc;

    mdu_ctrl_if u_if ();

    mdu_ctrl #(
        .MUL_CYCLES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_exe(input instr_t op, input logic [31:0] a, input logic [31:0] b);
        u_if.EXE_Op   = op;
        u_if.EXE_BusA = a;
        u_if.EXE_BusB = b;
    endtask

    // Present one instruction for exactly one cycle (the accept cycle t).
    // Returns 1ns into cycle t+1.
    task automatic issue(input instr_t op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        set_exe(op, a, b);
        u_if.EXE_Start = 1'b1;
        @(posedge clk);
        #1;
        u_if.EXE_Start = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);
    endtask

    // Count consecutive cycles (sampled at negedge) that busy (sel=0) or stall (sel=1)
    // is high; bounded. Returns at the negedge of the first low cycle.
    task automatic count_high(input bit sel, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!(sel ? u_if.MDU_Stall : u_if.MDU_Busy)) break;
            n++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        u_if.EXE_Start = 1'b0;
        u_if.EXE_Flush = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hi", u_if.HI, 32'h0);
        check_eq("rst_lo", u_if.LO, 32'h0);
        check_eq("rst_busy", {31'h0, u_if.MDU_Busy}, 32'h0);
        check_eq("rst_stall", {31'h0, u_if.MDU_Stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // MTHI/MTLO, then reset in the middle of a divide
        issue(OP_MTHI, 32'h0000_1234, 32'h0);
        issue(OP_MTLO, 32'h0000_5678, 32'h0);
        @(negedge clk);
        check_eq("mthi", u_if.HI, 32'h0000_1234);
        check_eq("mtlo", u_if.LO, 32'h0000_5678);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        set_exe(OP_MFHI, 32'h0, 32'h0);
        u_if.EXE_Start = 1'b1;
        #1;
        check_eq("midrst_hi", u_if.HI, 32'h0);
        check_eq("midrst_lo", u_if.LO, 32'h0);
        check_eq("midrst_busy", {31'h0, u_if.MDU_Busy}, 32'h0);
        check_eq("midrst_stall", {31'h0, u_if.MDU_Stall}, 32'h0);
        u_if.EXE_Start = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        issue(OP_DIV, 32'd100, 32'd7);
        count_high(1'b0, n_cyc);
        check_eq("div100_cycles", n_cyc, 32'd33);
        check_eq("div100_lo", u_if.LO, 32'd14);
        check_eq("div100_hi", u_if.HI, 32'd2);

        // Multiplies
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        count_high(1'b0, n_cyc);
        check_eq("mult_cycles", n_cyc, 32'd2);
        check_eq("mult_hi", u_if.HI, 32'hFFFF_FFFF);
        check_eq("mult_lo", u_if.LO, 32'hFFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        count_high(1'b0, n_cyc);
        check_eq("multu_hi", u_if.HI, 32'h0000_0001);
        check_eq("multu_lo", u_if.LO, 32'hFFFF_FFFE);

        // Divides
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_high(1'b0, n_cyc);
        check_eq("divneg_cycles", n_cyc, 32'd33);
        check_eq("divneg_lo", u_if.LO, 32'hFFFF_FFFD);
        check_eq("divneg_hi", u_if.HI, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'd5, 32'd0);
        count_high(1'b0, n_cyc);
        check_eq("divz_lo", u_if.LO, 32'hFFFF_FFFF);
        check_eq("divz_hi", u_if.HI, 32'd5);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_high(1'b0, n_cyc);
        check_eq("divovf_lo", u_if.LO, 32'h8000_0000);
        check_eq("divovf_hi", u_if.HI, 32'h0);

        // MFHI stalled behind a divide
        issue(OP_DIV, 32'd23, 32'd5);
        set_exe(OP_MFHI, 32'h0, 32'h0);
        u_if.EXE_Start = 1'b1;
        count_high(1'b1, n_cyc);
        check_eq("mfhi_stall_cycles", n_cyc, 32'd33);
        check_eq("mfhi_hi", u_if.HI, 32'd3);
        @(posedge clk);
        #1 u_if.EXE_Start = 1'b0;

        // MTLO stalled behind a divide, written at end of its release cycle
        issue(OP_DIVU, 32'd23, 32'd5);
        set_exe(OP_MTLO, 32'h0000_ABCD, 32'h0);
        u_if.EXE_Start = 1'b1;
        count_high(1'b1, n_cyc);
        check_eq("mtlo_stall_cycles", n_cyc, 32'd33);
        check_eq("mtlo_before", u_if.LO, 32'd4);
        @(posedge clk);
        #1 u_if.EXE_Start = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("mtlo_after", u_if.LO, 32'h0000_ABCD);
        check_eq("mtlo_busy", {31'h0, u_if.MDU_Busy}, 32'h0);

        // Start and flush in the same cycle: no accept, no write
        @(posedge clk);
        #1;
        set_exe(OP_DIV, 32'd50, 32'd5);
        u_if.EXE_Start = 1'b1;
        u_if.EXE_Flush = 1'b1;
        @(negedge clk);
        check_eq("flush_div_stall", {31'h0, u_if.MDU_Stall}, 32'h0);
        @(posedge clk);
        #1 set_exe(OP_MTHI, 32'h0BAD_0BAD, 32'h0);
        @(negedge clk);
        check_eq("flush_div_busy", {31'h0, u_if.MDU_Busy}, 32'h0);
        @(posedge clk);
        #1;
        u_if.EXE_Start = 1'b0;
        u_if.EXE_Flush = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("flush_hi", u_if.HI, 32'd3);
        check_eq("flush_lo", u_if.LO, 32'h0000_ABCD);

        // MFLO stalled, then flushed; non-MDU op never stalls
        issue(OP_DIV, 32'd9, 32'd3);
        set_exe(OP_MFLO, 32'h0, 32'h0);
        u_if.EXE_Start = 1'b1;
        @(negedge clk);
        check_eq("mflo_stall", {31'h0, u_if.MDU_Stall}, 32'h1);
        @(posedge clk);
        #1 u_if.EXE_Flush = 1'b1;
        @(negedge clk);
        check_eq("mflo_flush_stall", {31'h0, u_if.MDU_Stall}, 32'h0);
        check_eq("mflo_flush_busy", {31'h0, u_if.MDU_Busy}, 32'h1);
        @(posedge clk);
        #1;
        u_if.EXE_Flush = 1'b0;
        set_exe(OP_ADD, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("add_no_stall", {31'h0, u_if.MDU_Stall}, 32'h0);
        @(posedge clk);
        #1;
        u_if.EXE_Start = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);
        count_high(1'b0, n_cyc);
        check_eq("div9_lo", u_if.LO, 32'd3);
        check_eq("div9_hi", u_if.HI, 32'd0);

        // Accumulate ops
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'd5, 32'h0);
`ifdef MDU_ACC_EN
        issue(OP_MADD, 32'd3, 32'd4);
        count_high(1'b0, n_cyc);
        check_eq("madd_cycles", n_cyc, 32'd2);
        check_eq("madd_hi", u_if.HI, 32'h0);
        check_eq("madd_lo", u_if.LO, 32'd17);
        issue(OP_MSUBU, 32'd1, 32'd18);
        count_high(1'b0, n_cyc);
        check_eq("msubu_hi", u_if.HI, 32'hFFFF_FFFF);
        check_eq("msubu_lo", u_if.LO, 32'hFFFF_FFFF);
`else
        issue(OP_MADD, 32'd3, 32'd4);
        @(negedge clk);
        check_eq("madd_off_busy", {31'h0, u_if.MDU_Busy}, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("madd_off_hi", u_if.HI, 32'h0);
        check_eq("madd_off_lo", u_if.LO, 32'd5);
        issue(OP_DIVU, 32'd8, 32'd2);
        set_exe(OP_MADD, 32'd3, 32'd4);
        u_if.EXE_Start = 1'b1;
        @(negedge clk);
        check_eq("madd_off_stall", {31'h0, u_if.MDU_Stall}, 32'h0);
        @(posedge clk);
        #1;
        u_if.EXE_Start = 1'b0;
        set_exe(OP_NOP, 32'h0, 32'h0);
        count_high(1'b0, n_cyc);
        check_eq("div8_lo", u_if.LO, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
